// File: rtl/ubit_acc_bi_pkg.sv
// Shared FSM state encodings for the unary accumulator and the multiplier controllers.
// The multiplier controllers import the same encodings so both sides agree on them.
package ubit_acc_bi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/ubit_acc_bi_frame_cnt.sv
// BITWIDTH-bit frame counter with synchronous clear, count enable and a terminal count at N-1.
// Other unary stages reuse it for frame timing.
module frame_cnt #(
    parameter int BITWIDTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                en_i,
    output logic [BITWIDTH-1:0] cnt_o,
    output logic                tc_o
);

    logic [BITWIDTH-1:0] cntQ;
    logic [BITWIDTH-1:0] cntD;

    // Clear has priority over enable; the count wraps to 0 naturally after N-1.
    always_comb begin
        cntD = cntQ;
        if (clr_i) begin
            cntD = '0;
        end else if (en_i) begin
            cntD = cntQ + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cntQ <= '0;
        end else begin
            cntQ <= cntD;
        end
    end

    assign cnt_o = cntQ;
    assign tc_o  = (cntQ == {BITWIDTH{1'b1}});

endmodule

// File: rtl/ubit_acc_bi.sv
// Bipolar unary-to-binary accumulator: sequences one 2^BITWIDTH-cycle multiplier frame,
// counts the ones in the product stream and returns C - 2^(BITWIDTH-1) on a valid/ready handshake.
module ubit_acc_bi
    import ubit_acc_bi_pkg::*;
#(
    parameter int BITWIDTH = 8
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iStart,
    input  logic                iBit,
    input  logic                iReady,
    output logic                oLoadB,
    output logic                oClr,
    output logic                oBusy,
    output logic                oValid,
    output logic [BITWIDTH:0]   oCount,
    output logic [BITWIDTH:0]   oData
);

    localparam logic [BITWIDTH:0] HALF = (BITWIDTH + 1)'(1) << (BITWIDTH - 1);

    state_e              stateQ;
    state_e              stateD;
    logic [BITWIDTH:0]   onesQ;
    logic [BITWIDTH:0]   onesD;
    logic [BITWIDTH:0]   countQ;
    logic [BITWIDTH:0]   countD;
    logic [BITWIDTH:0]   dataQ;
    logic [BITWIDTH:0]   dataD;
    logic [BITWIDTH:0]   onesSum;
    logic [BITWIDTH-1:0] frameCnt;
    logic                frameClr;
    logic                frameEn;
    logic                frameTc;

    frame_cnt #(
        .BITWIDTH (BITWIDTH)
    ) uFrameCnt (
        .clk_i  (iClk),
        .rst_ni (iRstN),
        .clr_i  (frameClr),
        .en_i   (frameEn),
        .cnt_o  (frameCnt),
        .tc_o   (frameTc)
    );

    // The last sample is folded in combinationally so the result captures all N bits.
    assign onesSum = onesQ + {{BITWIDTH{1'b0}}, iBit};

    always_comb begin
        stateD   = stateQ;
        onesD    = onesQ;
        countD   = countQ;
        dataD    = dataQ;
        frameClr = 1'b0;
        frameEn  = 1'b0;
        case (stateQ)
            ST_IDLE: begin
                if (iStart) begin
                    stateD = ST_LOAD;
                end
            end
            ST_LOAD: begin
                frameClr = 1'b1;
                onesD    = '0;
                stateD   = ST_RUN;
            end
            ST_RUN: begin
                frameEn = 1'b1;
                onesD   = onesSum;
                if (frameTc) begin
                    countD = onesSum;
                    dataD  = onesSum - HALF;
                    stateD = ST_DONE;
                end
            end
            ST_DONE: begin
                if (iReady) begin
                    stateD = ST_IDLE;
                end
            end
            default: begin
                stateD = ST_IDLE;
            end
        endcase
    end

    // oData has its own register so its reset value is 0 rather than -2^(BITWIDTH-1).
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            stateQ <= ST_IDLE;
            onesQ  <= '0;
            countQ <= '0;
            dataQ  <= '0;
        end else begin
            stateQ <= stateD;
            onesQ  <= onesD;
            countQ <= countD;
            dataQ  <= dataD;
        end
    end

    assign oLoadB = (stateQ == ST_LOAD);
    assign oClr   = (stateQ == ST_LOAD);
    assign oBusy  = (stateQ == ST_LOAD) || (stateQ == ST_RUN);
    assign oValid = (stateQ == ST_DONE);
    assign oCount = countQ;
    assign oData  = dataQ;

    logic unusedFrameCnt;
    assign unusedFrameCnt = ^frameCnt;

endmodule

// File: tb/tb_ubit_acc_bi.sv
// Self-checking bench for ubit_acc_bi at BITWIDTH=4: directed and random frames
// checked against a ones-count reference model, plus handshake, restart and reset cases.
module tb_ubit_acc_bi;

    localparam int BW = 4;
    localparam int N  = 16;

    logic          iClk = 1'b0;
    logic          iRstN;
    logic          iStart;
    logic          iBit;
    logic          iReady;
    logic          oLoadB;
    logic          oClr;
    logic          oBusy;
    logic          oValid;
    logic [BW:0]   oCount;
    logic [BW:0]   oData;

    int total = 0;
    int bad   = 0;

    ubit_acc_bi #(
        .BITWIDTH (BW)
    ) dut (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iStart (iStart),
        .iBit   (iBit),
        .iReady (iReady),
        .oLoadB (oLoadB),
        .oClr   (oClr),
        .oBusy  (oBusy),
        .oValid (oValid),
        .oCount (oCount),
        .oData  (oData)
    );

    always #5 iClk = ~iClk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // Reference model: bipolar value is simply the popcount minus half the frame length.
    function automatic int modelCount(input logic [N-1:0] bits);
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(bits[i]);
        return c;
    endfunction

    function automatic logic [BW:0] modelData(input int c);
        return (BW + 1)'(c - N / 2);
    endfunction

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_loadb"}, oLoadB, 0);
        checkOutput({tag, "_clr"},   oClr,   0);
        checkOutput({tag, "_busy"},  oBusy,  0);
        checkOutput({tag, "_valid"}, oValid, 0);
        checkOutput({tag, "_count"}, oCount, 0);
        checkOutput({tag, "_data"},  oData,  0);
    endtask

    // Runs one frame from IDLE; restartAt pulses iStart during that RUN sample (-1 = none).
    task automatic applyStimulus(input string tag, input logic [N-1:0] bits,
                                 input int restartAt, input int readyDelay);
        int          expCount;
        logic [BW:0] expData;
        int          loadPulses;
        expCount   = modelCount(bits);
        expData    = modelData(expCount);
        loadPulses = 0;

        iStart = 1'b1;
        iReady = 1'b0;
        tick();
        iStart = 1'b0;
        checkOutput({tag, "_load_strobe"}, oLoadB, 1);
        checkOutput({tag, "_clr_strobe"},  oClr,   1);
        checkOutput({tag, "_load_busy"},   oBusy,  1);
        loadPulses += int'(oLoadB);
        iBit = 1'($urandom);
        tick();

        for (int i = 0; i < N; i++) begin
            iBit   = bits[i];
            iStart = (i == restartAt);
            iReady = 1'($urandom);
            loadPulses += int'(oLoadB) + int'(oClr);
            if (i == 0 || i == N - 1) begin
                checkOutput({tag, "_run_busy"},  oBusy,  1);
                checkOutput({tag, "_run_valid"}, oValid, 0);
            end
            tick();
        end
        iStart = 1'b0;
        iReady = 1'b0;

        checkOutput({tag, "_strobe_once"}, loadPulses, 1);
        checkOutput({tag, "_valid"},       oValid,     1);
        checkOutput({tag, "_done_busy"},   oBusy,      0);
        checkOutput({tag, "_count"},       oCount,     expCount);
        checkOutput({tag, "_data"},        oData,      expData);

        for (int d = 0; d < readyDelay; d++) begin
            iBit   = ~iBit;
            iStart = (d % 3 == 1);
            tick();
            checkOutput({tag, "_hold_valid"}, oValid, 1);
            checkOutput({tag, "_hold_data"},  oData,  expData);
            checkOutput({tag, "_hold_count"}, oCount, expCount);
            checkOutput({tag, "_hold_load"},  oLoadB, 0);
        end

        iReady = 1'b1;
        iStart = 1'b1;
        tick();
        iReady = 1'b0;
        iStart = 1'b0;
        checkOutput({tag, "_xfer_valid"}, oValid, 0);
        checkOutput({tag, "_xfer_busy"},  oBusy,  0);
        checkOutput({tag, "_xfer_load"},  oLoadB, 0);
        tick();
        checkOutput({tag, "_idle_load"},  oLoadB, 0);
        checkOutput({tag, "_idle_busy"},  oBusy,  0);
    endtask

    initial begin
        iRstN  = 1'b0;
        iStart = 1'b0;
        iBit   = 1'b0;
        iReady = 1'b0;
        #12;
        checkAllZero("reset");
        iRstN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("idle_valid", oValid, 0);
            checkOutput("idle_busy",  oBusy,  0);
        end

        $display("[TB] directed frames");
        applyStimulus("all_ones",  16'hFFFF, -1, 0);
        checkOutput("all_ones_pos8", oData, 5'b01000);
        applyStimulus("all_zeros", 16'h0000, -1, 1);
        checkOutput("all_zeros_neg8", oData, 5'b11000);
        applyStimulus("alternate", 16'h5555, -1, 0);
        applyStimulus("hold10",    16'($urandom), -1, 10);
        applyStimulus("restart5",  16'($urandom) | 16'h0100, 5, 2);

        $display("[TB] random frames");
        for (int f = 0; f < 4; f++) begin
            applyStimulus("random", 16'($urandom), -1, int'($urandom_range(0, 3)));
        end

        $display("[TB] reset during RUN");
        applyStimulus("pre_abort", 16'h00FF, -1, 0);
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            iBit = 1'b1;
            tick();
        end
        checkOutput("abort_busy", oBusy, 1);
        #2;
        iRstN = 1'b0;
        #1;
        checkAllZero("abort");
        tick();
        iRstN = 1'b1;
        tick();
        checkOutput("abort_idle_valid", oValid, 0);
        checkOutput("abort_idle_busy",  oBusy,  0);
        applyStimulus("fresh_ones", 16'hFFFF, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
